cosine_controller: RTL and testbench



---
 rtl/cosine_pkg.sv | 22 ++
 rtl/cosine_controller_if.sv | 35 +++
 rtl/cosine_controller_cycle_counter.sv | 38 +++
 rtl/cosine_controller.sv | 154 +++++++++++++++
 tb/tb_cosine_controller.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cosine_pkg.sv
// rtl/cosine_pkg.sv - shared widths and state codes for the cosine/distance controller and datapath
//
// Purpose: single source of the 3-bit control codes the datapath decodes,
// plus the state and data widths shared by controller, interface and datapath.
// Ports: none (package).

package cosine_pkg;

  localparam int STATE_W = 3;
  localparam int DATA_W  = 16;

  // Codes 6 and 7 are never produced; the controller treats them as illegal.
  typedef enum logic [STATE_W-1:0] {
    ST_STANDBY     = 3'd0,
    ST_ALERT       = 3'd1,
    ST_START_CALC  = 3'd2,
    ST_ACCUMULATE  = 3'd3,
    ST_CALC_DIST   = 3'd4,
    ST_WAIT_DONE   = 3'd5
  } state_e;

endpackage

// File: rtl/cosine_controller_if.sv
// rtl/cosine_controller_if.sv - controller <-> datapath/consumer signal bundle
//
// Purpose: groups the request, datapath status, control code and result
// handshake signals of cosine_controller.
// Ports: none; signals are reached through the modports.
//   master : controller side (drives state/busy/result_valid/result/alarm/error)
//   slave  : datapath, sensor and result consumer side

interface cosine_controller_if;
  import cosine_pkg::*;

  logic                detect;
  logic                stop;
  logic                done;
  logic [DATA_W-1:0]   distance;
  logic                result_ack;

  logic [STATE_W-1:0]  state;
  logic                busy;
  logic                result_valid;
  logic [DATA_W-1:0]   result;
  logic                alarm;
  logic                error;

  modport master (
    input  detect, stop, done, distance, result_ack,
    output state, busy, result_valid, result, alarm, error
  );

  modport slave (
    output detect, stop, done, distance, result_ack,
    input  state, busy, result_valid, result, alarm, error
  );

endinterface

// File: rtl/cosine_controller_cycle_counter.sv
// rtl/cosine_controller_cycle_counter.sv - up-counter with sync clear, enable and terminal compare
//
// Purpose: dwell counter shared by the Alert qualify count and the
// Accumulate/WaitDone timeouts.
// Ports:
//   clk        in  clock
//   rst        in  asynchronous active-high reset
//   clr_i      in  synchronous clear (has priority over enable)
//   en_i       in  count enable
//   terminal_i in  WIDTH  compare value
//   tc_o       out count equals terminal_i

module cycle_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] terminal_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign tc_o = (count_q == terminal_i);

endmodule

// File: rtl/cosine_controller.sv
// rtl/cosine_controller.sv - sequencer for one cosine/distance measurement per qualified detect
//
// Purpose: debounces detect, steps the datapath through its control codes,
// guards accumulation and completion with timeouts, and returns the distance
// through a valid/ack handshake with a threshold alarm.
// Ports:
//   clk         in  clock, rising edge
//   asyncclear  in  asynchronous active-high reset
//   bus         master modport: detect/stop/done/distance/result_ack in,
//               state/busy/result_valid/result/alarm/error out

module cosine_controller
  import cosine_pkg::*;
#(
  parameter int                ALERT_CYCLES = 2,
  parameter int                ACC_TIMEOUT  = 12,
  parameter int                DONE_TIMEOUT = 4,
  parameter logic [DATA_W-1:0] THRESHOLD    = 16'h0800
) (
  input  logic                 clk,
  input  logic                 asyncclear,
  cosine_controller_if.master  bus
);

  localparam int CNT_W = 8;

  // The counter starts at 0 on state entry, so the Nth cycle in a state sees N-1.
  localparam logic [CNT_W-1:0] ALERT_TC = CNT_W'(ALERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACC_TC   = CNT_W'(ACC_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DONE_TC  = CNT_W'(DONE_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic               busy_q;
  logic               result_valid_q;
  logic [DATA_W-1:0]  result_q;
  logic               alarm_q;
  logic               error_q;

  logic               cnt_en;
  logic               cnt_clr;
  logic [CNT_W-1:0]   cnt_terminal;
  logic               cnt_tc;

  logic               accept;
  logic               capture;
  logic               timeout;

  cycle_counter #(.WIDTH(CNT_W)) u_cycle_counter (
    .clk        (clk),
    .rst        (asyncclear),
    .clr_i      (cnt_clr),
    .en_i       (cnt_en),
    .terminal_i (cnt_terminal),
    .tc_o       (cnt_tc)
  );

  always_comb begin
    state_d      = state_q;
    cnt_en       = 1'b0;
    cnt_terminal = '0;
    accept       = 1'b0;
    capture      = 1'b0;
    timeout      = 1'b0;
    case (state_q)
      ST_STANDBY: begin
        // A pending result blocks new requests; they are dropped, not queued.
        if (bus.detect && !result_valid_q) begin
          state_d = ST_ALERT;
          accept  = 1'b1;
        end
      end
      ST_ALERT: begin
        cnt_en       = 1'b1;
        cnt_terminal = ALERT_TC;
        if (!bus.detect) begin
          state_d = ST_STANDBY;
        end else if (cnt_tc) begin
          state_d = ST_START_CALC;
        end
      end
      ST_START_CALC: begin
        state_d = ST_ACCUMULATE;
      end
      ST_ACCUMULATE: begin
        cnt_en       = 1'b1;
        cnt_terminal = ACC_TC;
        // stop is tested first so it wins over a coincident timeout.
        if (bus.stop) begin
          state_d = ST_CALC_DIST;
        end else if (cnt_tc) begin
          state_d = ST_STANDBY;
          timeout = 1'b1;
        end
      end
      ST_CALC_DIST: begin
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        cnt_en       = 1'b1;
        cnt_terminal = DONE_TC;
        if (bus.done) begin
          state_d = ST_STANDBY;
          capture = 1'b1;
        end else if (cnt_tc) begin
          state_d = ST_STANDBY;
          timeout = 1'b1;
        end
      end
      default: begin
        state_d = ST_STANDBY;
      end
    endcase
  end

  // Every state change restarts the dwell count for the state being entered.
  assign cnt_clr = (state_d != state_q);

  always_ff @(posedge clk or posedge asyncclear) begin
    if (asyncclear) begin
      state_q        <= ST_STANDBY;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
      alarm_q        <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_STANDBY);

      // Capture beats ack; result and alarm otherwise hold until the next capture.
      if (capture) begin
        result_q       <= bus.distance;
        alarm_q        <= (bus.distance < THRESHOLD);
        result_valid_q <= 1'b1;
      end else if (bus.result_ack) begin
        result_valid_q <= 1'b0;
      end

      if (timeout) begin
        error_q <= 1'b1;
      end else if (accept) begin
        error_q <= 1'b0;
      end
    end
  end

  assign bus.state        = state_q;
  assign bus.busy         = busy_q;
  assign bus.result_valid = result_valid_q;
  assign bus.result       = result_q;
  assign bus.alarm        = alarm_q;
  assign bus.error        = error_q;

endmodule

// File: tb/tb_cosine_controller.sv
// tb/tb_cosine_controller.sv - self-checking bench for cosine_controller

module tb_cosine_controller;

  localparam int ALERT_CYCLES = 2;
  localparam int ACC_TIMEOUT  = 12;
  localparam int DONE_TIMEOUT = 4;
  localparam int THRESHOLD    = 16'h0800;

  logic        clk = 1'b0;
  logic        asyncclear = 1'b1;
  logic        detect = 1'b0;
  logic        stop = 1'b0;
  logic        done = 1'b0;
  logic [15:0] distance = 16'h0000;
  logic        result_ack = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // datapath stub configuration: cycle within state 3 / state 5 that pulses stop / done
  int stop_at = 0;
  int done_at = 1;
  int sd = 0;
  logic [2:0] sd_prev = 3'd0;

  cosine_controller_if bus ();

  assign bus.detect     = detect;
  assign bus.stop       = stop;
  assign bus.done       = done;
  assign bus.distance   = distance;
  assign bus.result_ack = result_ack;

  cosine_controller #(
    .ALERT_CYCLES (ALERT_CYCLES),
    .ACC_TIMEOUT  (ACC_TIMEOUT),
    .DONE_TIMEOUT (DONE_TIMEOUT),
    .THRESHOLD    (16'(THRESHOLD))
  ) dut (
    .clk        (clk),
    .asyncclear (asyncclear),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_rv();
    int n;
    n = 0;
    while (bus.result_valid !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    lit("wait_result_valid", {31'd0, bus.result_valid}, 32'd1);
  endtask

  // Datapath stub: counts cycles spent in the current control code.
  always @(posedge clk) begin
    #2;
    if (bus.state != sd_prev) sd = 1;
    else sd = sd + 1;
    sd_prev = bus.state;
    stop = (bus.state == 3'd3) && (sd == stop_at);
    done = (bus.state == 3'd5) && (sd == done_at);
  end

  // Reference model: tracks the phase and how many cycles it has lasted.
  int          m_state = 0;
  int          m_dwell = 1;
  logic        m_rv = 1'b0;
  logic [15:0] m_res = 16'h0000;
  logic        m_alarm = 1'b0;
  logic        m_err = 1'b0;
  int          m_next;
  bit          m_cap;

  always @(posedge clk or posedge asyncclear) begin
    if (asyncclear) begin
      m_state = 0; m_dwell = 1; m_rv = 1'b0; m_res = 16'h0; m_alarm = 1'b0; m_err = 1'b0;
    end else begin
      m_next = m_state;
      m_cap  = 1'b0;
      case (m_state)
        0: if (detect && !m_rv) begin m_next = 1; m_err = 1'b0; end
        1: if (!detect) m_next = 0;
           else if (m_dwell >= ALERT_CYCLES) m_next = 2;
        2: m_next = 3;
        3: if (stop) m_next = 4;
           else if (m_dwell >= ACC_TIMEOUT) begin m_next = 0; m_err = 1'b1; end
        4: m_next = 5;
        5: if (done) begin m_next = 0; m_cap = 1'b1; end
           else if (m_dwell >= DONE_TIMEOUT) begin m_next = 0; m_err = 1'b1; end
        default: m_next = 0;
      endcase
      if (m_cap) begin
        m_rv = 1'b1;
        m_res = distance;
        m_alarm = (int'(distance) < THRESHOLD);
      end else if (result_ack) begin
        m_rv = 1'b0;
      end
      m_dwell = (m_next == m_state) ? m_dwell + 1 : 1;
      m_state = m_next;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      lit("cyc_state", {29'd0, bus.state}, m_state);
      lit("cyc_busy", {31'd0, bus.busy}, {31'd0, m_state != 0});
      lit("cyc_result_valid", {31'd0, bus.result_valid}, {31'd0, m_rv});
      lit("cyc_result", {16'd0, bus.result}, {16'd0, m_res});
      lit("cyc_alarm", {31'd0, bus.alarm}, {31'd0, m_alarm});
      lit("cyc_error", {31'd0, bus.error}, {31'd0, m_err});
    end
  end

  int seq[16];
  int exp_seq[16] = '{0, 1, 1, 2, 3, 3, 3, 3, 3, 3, 3, 3, 3, 4, 5, 0};
  int n3;
  bit left3;

  initial begin
    repeat (3) step();
    @(negedge clk);
    lit("reset_state", {29'd0, bus.state}, 0);
    lit("reset_busy", {31'd0, bus.busy}, 0);
    lit("reset_result_valid", {31'd0, bus.result_valid}, 0);
    lit("reset_result", {16'd0, bus.result}, 0);
    lit("reset_alarm", {31'd0, bus.alarm}, 0);
    lit("reset_error", {31'd0, bus.error}, 0);
    step();
    asyncclear = 1'b0;
    chk_en = 1'b1;
    step();

    // nominal run
    stop_at = 9; done_at = 1; distance = 16'h0400; detect = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      seq[i] = int'(bus.state);
      step();
      if (i == 2) detect = 1'b0;
    end
    for (int i = 0; i < 16; i++) lit($sformatf("nominal_seq[%0d]", i), seq[i], exp_seq[i]);
    lit("nominal_result", {16'd0, bus.result}, 32'h0400);
    lit("nominal_alarm", {31'd0, bus.alarm}, 1);
    repeat (3) step();
    lit("nominal_held", {31'd0, bus.result_valid}, 1);
    result_ack = 1'b1;
    step();
    result_ack = 1'b0;
    @(negedge clk);
    lit("nominal_acked", {31'd0, bus.result_valid}, 0);
    lit("nominal_result_hold", {16'd0, bus.result}, 32'h0400);

    // glitch
    step();
    detect = 1'b1;
    step();
    detect = 1'b0;
    @(negedge clk);
    lit("glitch_alert", {29'd0, bus.state}, 1);
    step();
    @(negedge clk);
    lit("glitch_back", {29'd0, bus.state}, 0);
    lit("glitch_busy", {31'd0, bus.busy}, 0);
    lit("glitch_error", {31'd0, bus.error}, 0);

    // accumulate timeout
    step();
    stop_at = 0; detect = 1'b1;
    repeat (3) step();
    detect = 1'b0;
    n3 = 0; left3 = 1'b0;
    for (int i = 0; i < 40 && !left3; i++) begin
      @(negedge clk);
      if (bus.state == 3'd3) n3++;
      else if (n3 > 0) left3 = 1'b1;
    end
    lit("timeout_dwell", n3, ACC_TIMEOUT);
    lit("timeout_state", {29'd0, bus.state}, 0);
    lit("timeout_error", {31'd0, bus.error}, 1);
    lit("timeout_no_result", {31'd0, bus.result_valid}, 0);
    step();
    stop_at = 9; done_at = 2; distance = 16'h1234; detect = 1'b1;
    step();
    @(negedge clk);
    lit("error_cleared", {31'd0, bus.error}, 0);
    step();
    step();
    detect = 1'b0;
    wait_rv();
    lit("recover_result", {16'd0, bus.result}, 32'h1234);

    // pending result blocks detect
    detect = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      lit("pending_ignored", {29'd0, bus.state}, 0);
    end
    step();
    detect = 1'b0;
    result_ack = 1'b1;
    step();
    result_ack = 1'b0;
    stop_at = 9; done_at = 1; distance = 16'h0900; detect = 1'b1;
    repeat (3) step();
    detect = 1'b0;
    wait_rv();
    lit("pending_result", {16'd0, bus.result}, 32'h0900);
    lit("pending_alarm", {31'd0, bus.alarm}, 0);
    result_ack = 1'b1;
    step();
    result_ack = 1'b0;

    // mid-run reset
    stop_at = 0; detect = 1'b1;
    repeat (3) step();
    detect = 1'b0;
    repeat (4) step();
    lit("pre_reset_state", {29'd0, bus.state}, 3);
    asyncclear = 1'b1;
    #1;
    lit("midreset_state", {29'd0, bus.state}, 0);
    lit("midreset_busy", {31'd0, bus.busy}, 0);
    lit("midreset_result_valid", {31'd0, bus.result_valid}, 0);
    lit("midreset_result", {16'd0, bus.result}, 0);
    step();
    step();
    asyncclear = 1'b0;
    step();

    // stop coincident with the accumulate timeout; boundary distance just below threshold
    stop_at = 12; done_at = 1; distance = 16'h07FF; detect = 1'b1;
    repeat (3) step();
    detect = 1'b0;
    n3 = 0; left3 = 1'b0;
    for (int i = 0; i < 40 && !left3; i++) begin
      @(negedge clk);
      if (bus.state == 3'd3) n3++;
      else if (n3 > 0) left3 = 1'b1;
    end
    lit("simul_dwell", n3, ACC_TIMEOUT);
    lit("simul_state", {29'd0, bus.state}, 4);
    lit("simul_error", {31'd0, bus.error}, 0);
    step();
    wait_rv();
    lit("simul_alarm", {31'd0, bus.alarm}, 1);
    result_ack = 1'b1;
    step();
    result_ack = 1'b0;

    // randomized traffic checked cycle by cycle against the model
    for (int r = 0; r < 800; r++) begin
      if (r % 25 == 0) begin
        stop_at = $urandom_range(0, 13);
        done_at = $urandom_range(1, 5);
      end
      if ($urandom_range(0, 1) == 0) distance = 16'(16'h07FF + $urandom_range(0, 2));
      else distance = 16'($urandom);
      detect = ($urandom_range(0, 3) != 0);
      result_ack = ($urandom_range(0, 7) == 0);
      step();
    end
    detect = 1'b0;
    result_ack = 1'b0;
    step();
    @(negedge clk);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
